// File: rtl/uart_rx_oversampled_if.sv
// Serial receive link: line input plus the received-byte strobe and status.
// master drives the line; slave is the receiver.
interface uart_rx_oversampled_if;
    logic       rx;
    logic       rx_rdy;
    logic [7:0] rx_bus;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        input  rx_rdy,
        input  rx_bus,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output rx_rdy,
        output rx_bus,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling.
// Emits a one-clk rx_rdy per good frame and frame_err per bad stop bit.
module uart_rx_oversampled #(
    parameter int DIVISOR    = 163,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_rx_oversampled_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [15:0] DIV_MAX = 16'(DIVISOR - 1);
    localparam logic [3:0]  HALF_T  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  FULL_T  = 4'(OVERSAMPLE - 1);

    state_t      state;
    state_t      state_nxt;
    logic        rx_m;
    logic        rx_s;
    logic [15:0] div;
    logic [3:0]  tcnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  rx_bus_q;
    logic        rx_rdy_q;
    logic        frame_err_q;

    logic tick;
    logic half;
    logic full;
    logic start_ok;
    logic sample;
    logic rdy_nxt;
    logic ferr_nxt;

    assign tick = (state != IDLE) && (div == DIV_MAX);
    assign half = tick && (tcnt == HALF_T);
    assign full = tick && (tcnt == FULL_T);

    // Two-flop synchronizer; idle-high so reset does not fake a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (half) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (full && (bit_idx == 3'd7)) state_nxt = STOP;
            end
            STOP: begin
                if (full) state_nxt = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output decode: strobes consumed by the datapath register.
    always_comb begin
        start_ok = (state == START) && half && !rx_s;
        sample   = (state == DATA) && full;
        rdy_nxt  = (state == STOP) && full && rx_s;
        ferr_nxt = (state == STOP) && full && !rx_s;
    end

    // Tick divider, tick counter, shifter and registered result pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            tcnt        <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_bus_q    <= '0;
            rx_rdy_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_rdy_q    <= rdy_nxt;
            frame_err_q <= ferr_nxt;
            if (state == IDLE) begin
                div  <= '0;
                tcnt <= '0;
            end else begin
                div <= tick ? '0 : div + 16'd1;
                if (start_ok) begin
                    tcnt <= '0;
                end else if (tick) begin
                    tcnt <= tcnt + 4'd1;
                end
            end
            if (start_ok) begin
                bit_idx <= '0;
            end else if (sample) begin
                bit_idx <= bit_idx + 3'd1;
                shreg   <= {rx_s, shreg[7:1]};
            end
            if (rdy_nxt) begin
                rx_bus_q <= shreg;
            end
        end
    end

    assign bus.rx_rdy    = rx_rdy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_bus    = rx_bus_q;
    assign bus.busy      = (state != IDLE) || rx_rdy_q;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled with DIVISOR=4 (64 clk per bit).
// Expected values are hand-derived from the 8N1 frame timing.
module tb_uart_rx_oversampled;
    localparam int BIT = 64;
    localparam int LAT = 611;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    uart_rx_oversampled_if u_if ();

    uart_rx_oversampled #(
        .DIVISOR    (4),
        .OVERSAMPLE (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         rdy_cnt;
    int         ferr_cnt;
    int         excl_bad;
    int         long_bad;
    int         rdy_cyc_q[$];
    logic [7:0] rdy_dat_q[$];
    logic       busy_at_rdy;
    logic       busy_after;
    logic       prev_rdy;
    logic       prev_ferr;

    initial begin
        rdy_cnt     = 0;
        ferr_cnt    = 0;
        excl_bad    = 0;
        long_bad    = 0;
        busy_at_rdy = 1'b0;
        busy_after  = 1'b1;
        prev_rdy    = 1'b0;
        prev_ferr   = 1'b0;
    end

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (u_if.rx_rdy) begin
            rdy_cnt++;
            rdy_cyc_q.push_back(cyc);
            rdy_dat_q.push_back(u_if.rx_bus);
            busy_at_rdy = u_if.busy;
        end
        if (prev_rdy) busy_after = u_if.busy;
        if (u_if.frame_err) ferr_cnt++;
        if (u_if.rx_rdy && u_if.frame_err) excl_bad++;
        if ((u_if.rx_rdy && prev_rdy) || (u_if.frame_err && prev_ferr))
            long_bad++;
        prev_rdy  = u_if.rx_rdy;
        prev_ferr = u_if.frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int fall_cyc;

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int per);
        fall_cyc = cyc;
        u_if.rx  = 1'b0;
        wait_clk(per);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = b[i];
            wait_clk(per);
        end
        u_if.rx = stop_bit;
        wait_clk(per);
    endtask

    function automatic logic [7:0] dat_at(input int i);
        return (i < rdy_dat_q.size()) ? rdy_dat_q[i] : 8'hxx;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < rdy_cyc_q.size()) ? rdy_cyc_q[i] : -1;
    endfunction

    int f1;

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        u_if.rx = 1'b1;
        wait_clk(5);
        check("reset_rx_rdy", u_if.rx_rdy, 0);
        check("reset_frame_err", u_if.frame_err, 0);
        check("reset_busy", u_if.busy, 0);
        check("reset_rx_bus", u_if.rx_bus, 8'h00);
        reset_n = 1'b1;
        wait_clk(10);

        send_frame(8'h01, 1'b1, BIT);
        wait_clk(20);
        check("b01_count", rdy_cnt, 1);
        check("b01_data", dat_at(0), 8'h01);
        check("b01_latency", cyc_at(0) - fall_cyc, LAT);
        check("b01_busy_in_pulse", busy_at_rdy, 1);
        check("b01_busy_after", busy_after, 0);
        check("b01_rx_bus", u_if.rx_bus, 8'h01);
        check("b01_no_ferr", ferr_cnt, 0);

        send_frame(8'hA5, 1'b1, BIT);
        f1 = fall_cyc;
        send_frame(8'h3C, 1'b1, BIT);
        wait_clk(20);
        check("b2b_count", rdy_cnt, 3);
        check("b2b_data_a5", dat_at(1), 8'hA5);
        check("b2b_data_3c", dat_at(2), 8'h3C);
        check("b2b_spacing", cyc_at(2) - cyc_at(1), 640);
        check("b2b_latency", cyc_at(1) - f1, LAT);
        check("b2b_rx_bus", u_if.rx_bus, 8'h3C);

        u_if.rx = 1'b0;
        wait_clk(20);
        u_if.rx = 1'b1;
        wait_clk(100);
        check("glitch_count", rdy_cnt, 3);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_busy", u_if.busy, 0);
        check("glitch_rx_bus", u_if.rx_bus, 8'h3C);

        send_frame(8'h55, 1'b0, BIT);
        wait_clk(300);
        check("brk_ferr_low", ferr_cnt, 1);
        check("brk_busy_low", u_if.busy, 1);
        u_if.rx = 1'b1;
        wait_clk(100);
        check("brk_ferr_total", ferr_cnt, 1);
        check("brk_count", rdy_cnt, 3);
        check("brk_rx_bus", u_if.rx_bus, 8'h3C);
        check("brk_busy_idle", u_if.busy, 0);

        u_if.rx = 1'b0;
        wait_clk(BIT);
        u_if.rx = 1'b1;
        wait_clk(4 * BIT + BIT / 2);
        check("abort_busy_pre", u_if.busy, 1);
        reset_n = 1'b0;
        wait_clk(3);
        check("abort_busy", u_if.busy, 0);
        check("abort_rx_bus", u_if.rx_bus, 8'h00);
        reset_n = 1'b1;
        wait_clk(6 * BIT);
        check("abort_count", rdy_cnt, 3);
        check("abort_idle", u_if.busy, 0);
        send_frame(8'h7E, 1'b1, BIT);
        wait_clk(20);
        check("post_abort_count", rdy_cnt, 4);
        check("post_abort_data", dat_at(3), 8'h7E);
        check("post_abort_ferr", ferr_cnt, 1);

        send_frame(8'hC3, 1'b1, 62);
        wait_clk(50);
        send_frame(8'hC3, 1'b1, 66);
        wait_clk(50);
        check("skew_count", rdy_cnt, 6);
        check("skew_fast_data", dat_at(4), 8'hC3);
        check("skew_slow_data", dat_at(5), 8'hC3);
        check("skew_ferr", ferr_cnt, 1);

        check("pulse_exclusive", excl_bad, 0);
        check("pulse_one_clk", long_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
